branch_ctrl: RTL and testbench

BRANCH_CTRL -- requirements
Module: branch_ctrl

---
 rtl/branch_ctrl.sv | 135 +++++++++++++
 tb/tb_branch_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_ctrl.sv
// Branch resolution controller: accepts one compare-and-branch request at a time,
// resolves condition and next PC, and flushes the pipeline on taken branches.
module branch_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_ir,
  input  logic [31:0]      req_pc,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             rd_taken,
  output logic [31:0]      rd_target,
  output logic             rd_illegal,
  output logic             flush,
  output logic             busy,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EVAL = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state_reg, state_next;
  logic             req_ready_reg;
  logic             rd_valid_reg;
  logic             rd_taken_reg;
  logic             rd_illegal_reg;
  logic [31:0]      rd_target_reg;
  logic             flush_reg;
  logic [CNT_W-1:0] taken_cnt_reg;

  logic [5:0]       op_reg;
  logic [15:0]      imm_reg;
  logic [31:0]      pc_reg, a_reg, b_reg;

  logic             accept, resp_done;
  logic             a_eq_b, a_lt_b;
  logic             eval_taken, eval_illegal;
  logic [31:0]      br_offset, eval_target;
  logic             unused_ir;

  // Bits between the opcode and the immediate carry no meaning for branches.
  assign unused_ir = ^req_ir[25:16];

  assign accept    = req_valid & req_ready_reg;
  assign resp_done = (state_reg == RESP) & rd_ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = EVAL;
      EVAL:    state_next = RESP;
      RESP:    if (rd_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Condition evaluation works only on the latched copy of the request.
  always_comb begin
    a_eq_b       = (a_reg == b_reg);
    a_lt_b       = ($signed(a_reg) < $signed(b_reg));
    eval_taken   = 1'b0;
    eval_illegal = 1'b0;
    case (op_reg)
      6'h08:   eval_taken = a_eq_b;
      6'h09:   eval_taken = ~a_eq_b;
      6'h0A:   eval_taken = ~a_lt_b;
      6'h0B:   eval_taken = ~a_lt_b & ~a_eq_b;
      6'h0C:   eval_taken = a_lt_b | a_eq_b;
      6'h0D:   eval_taken = a_lt_b;
      default: eval_illegal = 1'b1;
    endcase
    br_offset   = eval_taken ? {{14{imm_reg[15]}}, imm_reg, 2'b00} : 32'd0;
    eval_target = pc_reg + 32'd4 + br_offset;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      req_ready_reg  <= 1'b0;
      rd_valid_reg   <= 1'b0;
      rd_taken_reg   <= 1'b0;
      rd_illegal_reg <= 1'b0;
      rd_target_reg  <= 32'd0;
      flush_reg      <= 1'b0;
      taken_cnt_reg  <= '0;
      op_reg         <= 6'd0;
      imm_reg        <= 16'd0;
      pc_reg         <= 32'd0;
      a_reg          <= 32'd0;
      b_reg          <= 32'd0;
    end else begin
      state_reg     <= state_next;
      req_ready_reg <= (state_next == IDLE);
      rd_valid_reg  <= (state_next == RESP);
      flush_reg     <= resp_done & rd_taken_reg;

      if (accept) begin
        op_reg  <= req_ir[31:26];
        imm_reg <= req_ir[15:0];
        pc_reg  <= req_pc;
        a_reg   <= req_a;
        b_reg   <= req_b;
      end

      // Result registers are loaded once and then held for the whole RESP phase.
      if (state_reg == EVAL) begin
        rd_taken_reg   <= eval_taken;
        rd_illegal_reg <= eval_illegal;
        rd_target_reg  <= eval_target;
      end

      if (resp_done && rd_taken_reg && (taken_cnt_reg != CNT_MAX))
        taken_cnt_reg <= taken_cnt_reg + CNT_ONE;
    end
  end

  assign req_ready  = req_ready_reg;
  assign busy       = ~req_ready_reg;
  assign rd_valid   = rd_valid_reg;
  assign rd_taken   = rd_taken_reg;
  assign rd_illegal = rd_illegal_reg;
  assign rd_target  = rd_target_reg;
  assign flush      = flush_reg;
  assign taken_cnt  = taken_cnt_reg;

endmodule

// File: tb/tb_branch_ctrl.sv
// Randomized self-checking bench for branch_ctrl; a second instance with a
// 2-bit counter shares the stimulus to exercise counter saturation.
module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        rd_ready;
  logic [31:0] req_ir, req_pc, req_a, req_b;

  logic        req_ready, rd_valid, rd_taken, rd_illegal, flush, busy;
  logic [31:0] rd_target;
  logic [15:0] taken_cnt;

  logic        req_ready2, rd_valid2, rd_taken2, rd_illegal2, flush2, busy2;
  logic [31:0] rd_target2;
  logic [1:0]  taken_cnt2;

  int errors = 0;
  int checks = 0;
  int taken_total = 0;

  always #5 clk = ~clk;

  branch_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_ir(req_ir), .req_pc(req_pc), .req_a(req_a), .req_b(req_b),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_taken(rd_taken),
    .rd_target(rd_target), .rd_illegal(rd_illegal), .flush(flush),
    .busy(busy), .taken_cnt(taken_cnt)
  );

  branch_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready2),
    .req_ir(req_ir), .req_pc(req_pc), .req_a(req_a), .req_b(req_b),
    .rd_valid(rd_valid2), .rd_ready(rd_ready), .rd_taken(rd_taken2),
    .rd_target(rd_target2), .rd_illegal(rd_illegal2), .flush(flush2),
    .busy(busy2), .taken_cnt(taken_cnt2)
  );

  // Reference: branch rules evaluated with plain signed integer arithmetic.
  function automatic void ref_model(input logic [5:0] op, input logic [31:0] pc,
                                    input logic [31:0] a, input logic [31:0] b,
                                    input logic [15:0] imm, output logic t,
                                    output logic ill, output logic [31:0] tgt);
    int     sa, sb;
    longint off;
    sa  = int'(a);
    sb  = int'(b);
    ill = 1'b0;
    case (op)
      6'h08:   t = (sa == sb);
      6'h09:   t = (sa != sb);
      6'h0A:   t = (sa >= sb);
      6'h0B:   t = (sa > sb);
      6'h0C:   t = (sa <= sb);
      6'h0D:   t = (sa < sb);
      default: begin t = 1'b0; ill = 1'b1; end
    endcase
    off = t ? longint'($signed(imm)) * 4 : 64'sd0;
    tgt = 32'(longint'(pc) + 4 + off);
  endfunction

  function automatic logic [15:0] exp_cnt16();
    return (taken_total > 65535) ? 16'hFFFF : 16'(taken_total);
  endfunction

  function automatic logic [1:0] exp_cnt2();
    return (taken_total > 3) ? 2'd3 : 2'(taken_total);
  endfunction

  // One full transaction; caller is positioned 1 time unit after a rising edge.
  task automatic run_txn(input logic [5:0] op, input logic [31:0] pc, input logic [31:0] a,
                         input logic [31:0] b, input logic [15:0] imm, input int hold);
    logic        et, eil;
    logic [31:0] etg;
    int          n;
    ref_model(op, pc, a, b, imm, et, eil, etg);
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL ready_timeout: req_ready=%b required 1", req_ready);
    end
    req_valid = 1'b1;
    req_ir    = {op, 10'($urandom), imm};
    req_pc    = pc;
    req_a     = a;
    req_b     = b;
    rd_ready  = 1'b0;
    @(posedge clk); #1;
    // Garbage after acceptance must not leak into the result.
    req_ir = $urandom; req_pc = $urandom; req_a = $urandom; req_b = $urandom;
    checks++;
    if (rd_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0) begin
      errors++; $display("FAIL eval_phase: rd_valid=%b busy=%b req_ready=%b required 0 1 0",
                         rd_valid, busy, req_ready);
    end
    @(posedge clk); #1;
    for (int i = 0; i <= hold; i++) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_taken !== et || rd_target !== etg || rd_illegal !== eil ||
          req_ready !== 1'b0) begin
        errors++;
        $display("FAIL resp_hold[%0d]: valid=%b taken=%b tgt=%h ill=%b rdy=%b required 1 %b %h %b 0",
                 i, rd_valid, rd_taken, rd_target, rd_illegal, req_ready, et, etg, eil);
      end
      checks++;
      if (rd_taken2 !== et || rd_target2 !== etg || rd_illegal2 !== eil) begin
        errors++; $display("FAIL resp_sat_dut: taken=%b tgt=%h ill=%b required %b %h %b",
                           rd_taken2, rd_target2, rd_illegal2, et, etg, eil);
      end
      if (i < hold) begin
        @(posedge clk); #1;
      end
    end
    req_valid = 1'b0;
    rd_ready  = 1'b1;
    @(posedge clk); #1;
    rd_ready = 1'b0;
    if (et) taken_total++;
    checks++;
    if (rd_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0 || flush !== et) begin
      errors++; $display("FAIL after_handshake: valid=%b ready=%b busy=%b flush=%b required 0 1 0 %b",
                         rd_valid, req_ready, busy, flush, et);
    end
    checks++;
    if (taken_cnt !== exp_cnt16() || taken_cnt2 !== exp_cnt2()) begin
      errors++; $display("FAIL taken_cnt: got %0d/%0d required %0d/%0d",
                         taken_cnt, taken_cnt2, exp_cnt16(), exp_cnt2());
    end
    @(posedge clk); #1;
    checks++;
    if (flush !== 1'b0) begin
      errors++; $display("FAIL flush_width: flush=%b required 0", flush);
    end
    $display("txn op=%h pc=%h a=%h b=%h imm=%h -> taken=%b target=%h illegal=%b cnt=%0d",
             op, pc, a, b, imm, et, etg, eil, taken_cnt);
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 1'b0; rd_ready = 1'b0;
    req_ir = 32'd0; req_pc = 32'd0; req_a = 32'd0; req_b = 32'd0;
    #1;
    checks++;
    if ({req_ready, rd_valid, rd_taken, rd_target, rd_illegal, flush, taken_cnt} !== '0 ||
        busy !== 1'b1) begin
      errors++; $display("FAIL reset_state: ready=%b valid=%b tgt=%h flush=%b cnt=%0d busy=%b",
                         req_ready, rd_valid, rd_target, flush, taken_cnt, busy);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL reset_hold_ready: req_ready=%b required 0", req_ready);
    end
    #3 rst = 1'b1;
    taken_total = 0;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release: ready=%b busy=%b valid=%b required 1 0 0",
                         req_ready, busy, rd_valid);
    end
  endtask

  task automatic test_reset_mid_txn();
    for (int phase = 0; phase < 2; phase++) begin
      req_valid = 1'b1;
      req_ir = {6'h08, 10'd0, 16'h0004}; req_pc = 32'h100; req_a = 32'd5; req_b = 32'd5;
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (phase == 1) begin
        @(posedge clk); #1;
        checks++;
        if (rd_valid !== 1'b1) begin
          errors++; $display("FAIL resp_before_reset: rd_valid=%b required 1", rd_valid);
        end
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if ({req_ready, rd_valid, rd_taken, rd_target, rd_illegal, flush, taken_cnt} !== '0 ||
          taken_cnt2 !== 2'd0) begin
        errors++; $display("FAIL async_reset[%0d]: ready=%b valid=%b taken=%b tgt=%h flush=%b cnt=%0d",
                           phase, req_ready, rd_valid, rd_taken, rd_target, flush, taken_cnt);
      end
      #2 rst = 1'b1;
      taken_total = 0;
      @(posedge clk); #1;
      checks++;
      if (req_ready !== 1'b1 || flush !== 1'b0 || taken_cnt !== 16'd0) begin
        errors++; $display("FAIL reset_recover[%0d]: ready=%b flush=%b cnt=%0d required 1 0 0",
                           phase, req_ready, flush, taken_cnt);
      end
    end
  endtask

  task automatic test_directed();
    run_txn(6'h08, 32'h0000_0100, 32'd5, 32'd5, 16'h0004, 0);
    run_txn(6'h0D, 32'h0000_2000, 32'hFFFF_FFFF, 32'd1, 16'h0010, 0);
    run_txn(6'h0B, 32'h0000_2000, 32'hFFFF_FFFF, 32'd1, 16'h0010, 0);
    run_txn(6'h0A, 32'h0000_0000, 32'd7, 32'd7, 16'hFFFE, 0);
    run_txn(6'h0A, 32'h0000_0000, 32'd7, 32'd7, 16'hFFFF, 0);
    run_txn(6'h0C, 32'hFFFF_FFF8, 32'h8000_0000, 32'h7FFF_FFFF, 16'h0001, 0);
    run_txn(6'h00, 32'h0000_0400, 32'd3, 32'd3, 16'h0008, 0);
    run_txn(6'h0E, 32'h0000_0400, 32'd3, 32'd3, 16'h0008, 0);
  endtask

  task automatic test_hold();
    run_txn(6'h09, 32'h0000_1234, 32'd1, 32'd2, 16'h0100, 5);
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      logic [5:0]  op;
      logic [31:0] a, b;
      int          r;
      r  = int'($urandom_range(0, 15));
      op = (r < 12) ? 6'(8 + (r % 6)) : 6'($urandom);
      a  = $urandom;
      r  = int'($urandom_range(0, 2));
      b  = (r == 0) ? a : (r == 1) ? a + 32'($urandom_range(0, 2)) - 32'd1 : $urandom;
      run_txn(op, $urandom, a, b, 16'($urandom), int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_txn();
    test_directed();
    test_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
